i2c_target_regfile: RTL and testbench

// - I2C target (responder) with 16-bit register addressing and 8-bit data, matching the camera-sensor

---
 rtl/i2c_target_regfile.sv | 274 +++++++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// i2c_target_regfile
//
// I2C target with 16-bit register addressing and 8-bit data, laid out like a
// camera sensor register map. It lets the IIC master driver and its bring-up
// sequences run in loopback with no sensor fitted. The SDA pin sits behind an
// IOBUF using the _i/_o/_t split; sda_t=1 releases the line.
//
// Ports
//   clk_50m  in       system clock, rising edge
//   reset    in       asynchronous, active-high reset
//   scl_i    in       SCL from IOBUF.O
//   sda_i    in       SDA from IOBUF.O
//   sda_o    out      constant 0 (open-drain drive value)
//   sda_t    out      1 = release SDA, 0 = pull SDA low
//   wr_stb   out      one-cycle pulse per data byte written
//   wr_addr  out [16] register address of that write
//   wr_data  out [8]  data of that write
//   busy     out      high from START until STOP
//
// Build option
//   I2C_TGT_CHIP_ID_EN : when defined, addresses 0x300A/0x300B read back
//   CHIP_ID[15:8]/CHIP_ID[7:0]; writes there are ACKed but ignored and do
//   not strobe. When undefined those addresses behave like any other.
// ---------------------------------------------------------------------------
module i2c_target_regfile #(
  parameter logic [6:0]  DEV_ADDR = 7'h3C,
  parameter int          ADDR_W   = 8,
  parameter int          FILT_LEN = 4,
  parameter logic [15:0] CHIP_ID  = 16'h5640
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  output logic        wr_stb,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEVA,
    AHI,
    ALO,
    WDAT,
    RDAT,
    MACK
  } state_e;

  logic             sclMeta_q, sclSync_q, sclFilt_q, sclPrev_q;
  logic             sdaMeta_q, sdaSync_q, sdaFilt_q, sdaPrev_q;
  logic [CNT_W-1:0] sclCnt_q, sdaCnt_q;

  state_e      state_q;
  logic [3:0]  bitCnt_q;
  logic        ackPhase_q;
  logic [7:0]  rxByte_q;
  logic [6:0]  txByte_q;
  logic [7:0]  addrHi_q;
  logic [15:0] ptr_q;
  logic        sdaT_q;
  logic        wrStb_q;
  logic [15:0] wrAddr_q;
  logic [7:0]  wrData_q;
  logic        busy_q;
  logic [7:0]  mem_q [2**ADDR_W];

  logic sclRise, sclFall, startDet, stopDet, sdaIn;
  logic inRange, isChipId;
  logic [7:0] rdData;

  // Two-flop synchronisers followed by a stability filter: a new level is
  // accepted only after it has been seen on FILT_LEN consecutive clocks, so a
  // short glitch never reaches the edge detectors. The bus idles high.
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclFilt_q <= 1'b1;
      sclPrev_q <= 1'b1;
      sclCnt_q  <= '0;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaFilt_q <= 1'b1;
      sdaPrev_q <= 1'b1;
      sdaCnt_q  <= '0;
    end else begin
      sclMeta_q <= scl_i;
      sclSync_q <= sclMeta_q;
      sclPrev_q <= sclFilt_q;
      if (sclSync_q == sclFilt_q) begin
        sclCnt_q <= '0;
      end else if (sclCnt_q == CNT_MAX) begin
        sclFilt_q <= sclSync_q;
        sclCnt_q  <= '0;
      end else begin
        sclCnt_q <= sclCnt_q + 1'b1;
      end
      sdaMeta_q <= sda_i;
      sdaSync_q <= sdaMeta_q;
      sdaPrev_q <= sdaFilt_q;
      if (sdaSync_q == sdaFilt_q) begin
        sdaCnt_q <= '0;
      end else if (sdaCnt_q == CNT_MAX) begin
        sdaFilt_q <= sdaSync_q;
        sdaCnt_q  <= '0;
      end else begin
        sdaCnt_q <= sdaCnt_q + 1'b1;
      end
    end
  end

  // START/STOP need SCL to have been high on both sides of the SDA edge.
  assign sdaIn    = sdaFilt_q;
  assign sclRise  = sclFilt_q & ~sclPrev_q;
  assign sclFall  = ~sclFilt_q & sclPrev_q;
  assign startDet = sclFilt_q & sclPrev_q & sdaPrev_q & ~sdaFilt_q;
  assign stopDet  = sclFilt_q & sclPrev_q & ~sdaPrev_q & sdaFilt_q;

  // Pointers whose upper bits are non-zero fall outside the register file.
  assign inRange = ((ptr_q >> ADDR_W) == 16'd0);

`ifdef I2C_TGT_CHIP_ID_EN
  assign isChipId = (ptr_q == 16'h300A) || (ptr_q == 16'h300B);
`else
  assign isChipId = 1'b0;
`endif

  // Byte presented for the next read at the current pointer.
  always_comb begin
    rdData = 8'h00;
    if (isChipId) begin
      rdData = ptr_q[0] ? CHIP_ID[7:0] : CHIP_ID[15:8];
    end else if (inRange) begin
      rdData = mem_q[ptr_q[ADDR_W-1:0]];
    end
  end

  // Protocol FSM. START/STOP win over any bit edge seen in the same cycle.
  // Receive states count 8 SCL rises; the following SCL fall opens the ACK
  // slot (SDA pulled low) and the next fall closes it. Read data is driven
  // on SCL falls, MSB first, and the master's ACK is sampled in MACK.
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= 4'd0;
      ackPhase_q <= 1'b0;
      rxByte_q   <= 8'h00;
      txByte_q   <= 7'h00;
      addrHi_q   <= 8'h00;
      ptr_q      <= 16'h0000;
      sdaT_q     <= 1'b1;
      wrStb_q    <= 1'b0;
      wrAddr_q   <= 16'h0000;
      wrData_q   <= 8'h00;
      busy_q     <= 1'b0;
      mem_q      <= '{default: 8'h00};
    end else begin
      wrStb_q <= 1'b0;
      if (startDet) begin
        state_q    <= DEVA;
        bitCnt_q   <= 4'd0;
        ackPhase_q <= 1'b0;
        sdaT_q     <= 1'b1;
        busy_q     <= 1'b1;
      end else if (stopDet) begin
        state_q    <= IDLE;
        bitCnt_q   <= 4'd0;
        ackPhase_q <= 1'b0;
        sdaT_q     <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            sdaT_q <= 1'b1;
          end
          DEVA, AHI, ALO, WDAT: begin
            if (sclRise && !ackPhase_q && bitCnt_q != 4'd8) begin
              rxByte_q <= {rxByte_q[6:0], sdaIn};
              bitCnt_q <= bitCnt_q + 4'd1;
            end else if (sclFall && !ackPhase_q && bitCnt_q == 4'd8) begin
              bitCnt_q <= 4'd0;
              if (state_q == DEVA && rxByte_q[7:1] != DEV_ADDR) begin
                state_q <= IDLE;
              end else begin
                ackPhase_q <= 1'b1;
                sdaT_q     <= 1'b0;
                case (state_q)
                  AHI: addrHi_q <= rxByte_q;
                  ALO: ptr_q    <= {addrHi_q, rxByte_q};
                  WDAT: begin
                    if (!isChipId) begin
                      wrStb_q  <= 1'b1;
                      wrAddr_q <= ptr_q;
                      wrData_q <= rxByte_q;
                      if (inRange) begin
                        mem_q[ptr_q[ADDR_W-1:0]] <= rxByte_q;
                      end
                    end
                    ptr_q <= ptr_q + 16'd1;
                  end
                  default: ;
                endcase
              end
            end else if (sclFall && ackPhase_q) begin
              ackPhase_q <= 1'b0;
              sdaT_q     <= 1'b1;
              case (state_q)
                DEVA: begin
                  if (rxByte_q[0]) begin
                    state_q  <= RDAT;
                    txByte_q <= rdData[6:0];
                    sdaT_q   <= rdData[7];
                  end else begin
                    state_q <= AHI;
                  end
                end
                AHI:     state_q <= ALO;
                ALO:     state_q <= WDAT;
                default: state_q <= WDAT;
              endcase
            end
          end
          RDAT: begin
            if (sclRise && bitCnt_q != 4'd8) begin
              bitCnt_q <= bitCnt_q + 4'd1;
            end else if (sclFall && bitCnt_q == 4'd8) begin
              sdaT_q   <= 1'b1;
              ptr_q    <= ptr_q + 16'd1;
              bitCnt_q <= 4'd0;
              state_q  <= MACK;
            end else if (sclFall) begin
              sdaT_q   <= txByte_q[6];
              txByte_q <= {txByte_q[5:0], 1'b0};
            end
          end
          MACK: begin
            if (sclRise && !ackPhase_q) begin
              if (sdaIn) begin
                state_q <= IDLE;
              end else begin
                ackPhase_q <= 1'b1;
              end
            end else if (sclFall && ackPhase_q) begin
              ackPhase_q <= 1'b0;
              state_q    <= RDAT;
              txByte_q   <= rdData[6:0];
              sdaT_q     <= rdData[7];
            end
          end
          default: begin
            state_q <= IDLE;
            sdaT_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sda_o   = 1'b0;
  assign sda_t   = sdaT_q;
  assign wr_stb  = wrStb_q;
  assign wr_addr = wrAddr_q;
  assign wr_data = wrData_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regfile
//
// Drives the target through a bit-banged I2C master on a wired-AND SDA line.
// Expected write strobes are queued as the master sends each data byte and
// are matched by a strobe monitor; expected read bytes come from a small
// model of the register map.
// ---------------------------------------------------------------------------
module tb_i2c_target_regfile;

  localparam int Q = 10;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk_50m = 1'b0;
  logic        reset;
  logic        sclM;
  logic        sdaM;
  logic        sdaBus;
  logic        sda_o;
  logic        sda_t;
  logic        wr_stb;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int   vectors = 0;
  int   miscompares = 0;
  wr_t  wrQ[$];
  logic [7:0] rdQ[$];
  logic [7:0] tbMem [256];
  wr_t  expWr;

  i2c_target_regfile dut (
    .clk_50m (clk_50m),
    .reset   (reset),
    .scl_i   (sclM),
    .sda_i   (sdaBus),
    .sda_o   (sda_o),
    .sda_t   (sda_t),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  // Open-drain bus: either side may pull the line low.
  assign sdaBus = sdaM & (sda_t ? 1'b1 : sda_o);

  always #10 clk_50m = ~clk_50m;

  // Every strobe must match the oldest queued expected write.
  always @(negedge clk_50m) begin
    if (wr_stb === 1'b1) begin
      vectors++;
      if (wrQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL wr_stb_unexpected: got addr=%h data=%h, expected no strobe", wr_addr, wr_data);
      end else begin
        expWr = wrQ.pop_front();
        if ({wr_addr, wr_data} !== expWr) begin
          miscompares++;
          $display("[TB] FAIL wr_stb_payload: got addr=%h data=%h, expected addr=%h data=%h",
                   wr_addr, wr_data, expWr.addr, expWr.data);
        end
      end
    end
  end

  // Hard time limit in case the bench itself stalls.
  initial begin
    #1800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic modelClear();
    for (int i = 0; i < 256; i++) tbMem[i] = 8'h00;
  endtask

  function automatic logic [7:0] modelRead(input logic [15:0] a);
`ifdef I2C_TGT_CHIP_ID_EN
    if (a == 16'h300A) return 8'h56;
    if (a == 16'h300B) return 8'h40;
`endif
    if (a[15:8] != 8'h00) return 8'h00;
    return tbMem[a[7:0]];
  endfunction

  task automatic modelWrite(input logic [15:0] a, input logic [7:0] d);
`ifdef I2C_TGT_CHIP_ID_EN
    if (a == 16'h300A || a == 16'h300B) return;
`endif
    wrQ.push_back({a, d});
    if (a[15:8] == 8'h00) tbMem[a[7:0]] = d;
  endtask

  task automatic sendBit(input logic b, input logic glitch, output logic s);
    sdaM = b;
    if (glitch) begin
      waitClk(Q / 2);
      sclM = 1'b1;
      waitClk(1);
      sclM = 1'b0;
      waitClk(Q - Q / 2 - 1);
    end else begin
      waitClk(Q);
    end
    sclM = 1'b1;
    waitClk(Q);
    s = sdaBus;
    waitClk(Q);
    sclM = 1'b0;
    waitClk(Q);
  endtask

  task automatic i2cStart();
    sdaM = 1'b1;
    waitClk(Q);
    sclM = 1'b1;
    waitClk(Q);
    sdaM = 1'b0;
    waitClk(Q);
    sclM = 1'b0;
    waitClk(Q);
  endtask

  task automatic i2cStop();
    sdaM = 1'b0;
    waitClk(Q);
    sclM = 1'b1;
    waitClk(Q);
    sdaM = 1'b1;
    waitClk(2 * Q);
  endtask

  task automatic writeByte(input logic [7:0] b, input int glitchBit, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) sendBit(b[i], (i == glitchBit), s);
    sendBit(1'b1, 1'b0, s);
    acked = ~s;
  endtask

  task automatic readByte(input logic masterAck, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      sendBit(1'b1, 1'b0, s);
      b[i] = s;
    end
    sendBit(~masterAck, 1'b0, s);
  endtask

  task automatic sendAddr(input string tag, input logic [15:0] a, input int glitchBit);
    logic ack;
    writeByte(8'h78, glitchBit, ack);
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_dev_ack: got ack=%b, expected 1", tag, ack);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_busy: got %b, expected 1", tag, busy);
    end
    writeByte(a[15:8], glitchBit, ack);
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_ahi_ack: got ack=%b, expected 1", tag, ack);
    end
    writeByte(a[7:0], glitchBit, ack);
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_alo_ack: got ack=%b, expected 1", tag, ack);
    end
  endtask

  task automatic checkIdle(input string tag);
    waitClk(10);
    vectors++;
    if (busy !== 1'b0 || sda_t !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_idle: got busy=%b sda_t=%b, expected busy=0 sda_t=1", tag, busy, sda_t);
    end
  endtask

  task automatic doWrite(input string tag, input logic [15:0] a, input logic [23:0] d,
                         input int n, input int glitchBit);
    logic        ack;
    logic [15:0] p;
    logic [7:0]  b;
    p = a;
    i2cStart();
    sendAddr(tag, a, glitchBit);
    for (int i = 0; i < n; i++) begin
      b = d[23 - 8 * i -: 8];
      modelWrite(p, b);
      writeByte(b, glitchBit, ack);
      vectors++;
      if (ack !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL %s_data_ack[%0d]: got ack=%b, expected 1", tag, i, ack);
      end
      p = p + 16'd1;
    end
    i2cStop();
    checkIdle(tag);
  endtask

  task automatic doRead(input string tag, input logic [15:0] a, input int n);
    logic        ack;
    logic [15:0] p;
    logic [7:0]  got;
    logic [7:0]  exp;
    p = a;
    i2cStart();
    sendAddr(tag, a, -1);
    i2cStart();
    writeByte(8'h79, -1, ack);
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_rd_dev_ack: got ack=%b, expected 1", tag, ack);
    end
    for (int i = 0; i < n; i++) begin
      rdQ.push_back(modelRead(p));
      readByte(i != n - 1, got);
      exp = rdQ.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL %s_rd_byte[%0d]: got %h, expected %h", tag, i, got, exp);
      end
      p = p + 16'd1;
    end
    i2cStop();
    checkIdle(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sclM  = 1'b1;
    sdaM  = 1'b1;
    modelClear();
    waitClk(5);
    reset = 1'b0;
    waitClk(2);
    vectors++;
    if ({sda_t, sda_o, wr_stb, busy} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got sda_t=%b sda_o=%b wr_stb=%b busy=%b, expected 1 0 0 0",
               sda_t, sda_o, wr_stb, busy);
    end
    vectors++;
    if ({wr_addr, wr_data} !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL reset_wr_bus: got addr=%h data=%h, expected 0000 00", wr_addr, wr_data);
    end
    doRead("reset_mem", 16'h0050, 1);
  endtask

  task automatic test_write_read();
    doWrite("single_wr", 16'h0012, 24'hA50000, 1, -1);
    doRead("single_rd", 16'h0012, 1);
  endtask

  task automatic test_wrong_device();
    logic ack;
    i2cStart();
    writeByte(8'h7A, -1, ack);
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wrong_dev_nack: got ack=%b, expected 0", ack);
    end
    i2cStop();
    checkIdle("wrong_dev");
    doWrite("after_wrong_wr", 16'h0013, 24'h5A0000, 1, -1);
    doRead("after_wrong_rd", 16'h0013, 1);
  endtask

  task automatic test_burst();
    // 0x0100 lies outside the register file, so the third byte only strobes.
    doWrite("burst_wr", 16'h00FE, 24'hFF0011, 3, -1);
    doRead("burst_rd", 16'h00FE, 2);
  endtask

  task automatic test_wrap();
    doWrite("wrap_seed", 16'h0000, 24'h3C0000, 1, -1);
    doRead("wrap_rd", 16'hFFFF, 2);
  endtask

  task automatic test_chip_id();
    doRead("chipid_rd", 16'h300A, 2);
    doWrite("chipid_wr", 16'h300A, 24'h770000, 1, -1);
    doRead("chipid_rd2", 16'h300A, 2);
  endtask

  task automatic test_glitch();
    doWrite("glitch_wr", 16'h0021, 24'h960000, 1, 3);
    doRead("glitch_rd", 16'h0021, 1);
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    i2cStart();
    sendAddr("rst_mid", 16'h0000, -1);
    i2cStart();
    writeByte(8'h79, -1, ack);
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_rd_ack: got ack=%b, expected 1", ack);
    end
    vectors++;
    if (sda_t !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_driving: got sda_t=%b, expected 0", sda_t);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (sda_t !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_release: got sda_t=%b busy=%b, expected 1 0", sda_t, busy);
    end
    waitClk(3);
    reset = 1'b0;
    modelClear();
    waitClk(2);
    i2cStop();
    doWrite("post_rst_wr", 16'h0005, 24'hC30000, 1, -1);
    doRead("post_rst_rd", 16'h0005, 1);
    doRead("post_rst_clr", 16'h0000, 1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrong_device();
    test_burst();
    test_wrap();
    test_chip_id();
    test_glitch();
    test_reset_mid_read();
    waitClk(5);
    vectors++;
    if (wrQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL strobe_count: got %0d strobes still pending, expected 0", wrQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
